// File: rtl/microseq.sv
// Am2910-style microprogram sequencer: micro-PC, loop/count register R and a
// small LIFO stack produce the next control-store address Y each cycle.
module microseq #(
  parameter int AW    = 12,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    I,
  input  logic          cc,
  input  logic          nCCEN,
  input  logic          nRLD,
  input  logic          CI,
  input  logic [AW-1:0] D,
  output logic [AW-1:0] Y,
  output logic          nPL,
  output logic          nMAP,
  output logic          nVECT,
  output logic          nFULL
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [3:0] {
    JZ   = 4'd0,  CJS  = 4'd1,  JMAP = 4'd2,  CJP  = 4'd3,
    PUSH = 4'd4,  JSRP = 4'd5,  CJV  = 4'd6,  JRP  = 4'd7,
    RFCT = 4'd8,  RPCT = 4'd9,  CRTN = 4'd10, CJPP = 4'd11,
    LDCT = 4'd12, LOOP = 4'd13, CONT = 4'd14, TWB  = 4'd15
  } instr_t;

  instr_t         op;
  logic [AW-1:0]  upc;
  logic [AW-1:0]  r;
  logic [AW-1:0]  tos;
  logic [AW-1:0]  stk [DEPTH];
  logic [SPW-1:0] sp;
  logic           pass, r_zero;
  logic           push, pop, clr, r_dec, r_load;

  assign op     = instr_t'(I);
  assign pass   = nCCEN | cc;
  assign r_zero = (r == '0);
  // An empty stack reads entry 0 rather than an undefined slot.
  assign tos    = (sp == '0) ? stk[0] : stk[sp - SPW'(1)];

  assign nMAP  = (op != JMAP);
  assign nVECT = (op != CJV);
  assign nPL   = (op == JMAP) || (op == CJV);
  assign nFULL = (sp != SP_FULL);

  always_comb begin
    Y      = upc;
    push   = 1'b0;
    pop    = 1'b0;
    clr    = 1'b0;
    r_dec  = 1'b0;
    r_load = 1'b0;
    case (op)
      JZ:   begin Y = '0; clr = 1'b1; end
      CJS:  if (pass) begin Y = D; push = 1'b1; end
      JMAP: Y = D;
      CJP:  if (pass) Y = D;
      PUSH: begin push = 1'b1; r_load = pass; end
      JSRP: begin push = 1'b1; Y = pass ? D : r; end
      CJV:  if (pass) Y = D;
      JRP:  Y = pass ? D : r;
      RFCT: if (!r_zero) begin Y = tos; r_dec = 1'b1; end
            else pop = 1'b1;
      RPCT: if (!r_zero) begin Y = D; r_dec = 1'b1; end
      CRTN: if (pass) begin Y = tos; pop = 1'b1; end
      CJPP: if (pass) begin Y = D; pop = 1'b1; end
      LDCT: r_load = 1'b1;
      LOOP: if (pass) pop = 1'b1;
            else Y = tos;
      CONT: ;
      TWB:  if (pass) pop = 1'b1;
            else if (!r_zero) begin Y = tos; r_dec = 1'b1; end
            else begin Y = D; pop = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc <= '0;
      r   <= '0;
      sp  <= '0;
      for (int k = 0; k < DEPTH; k++) stk[k] <= '0;
    end else begin
      upc <= Y + {{(AW-1){1'b0}}, CI};

      // External load has priority over any instruction effect on R.
      if (!nRLD)       r <= D;
      else if (r_load) r <= D;
      else if (r_dec)  r <= r - AW'(1);

      if (clr) begin
        sp <= '0;
      end else if (push) begin
        if (sp == SP_FULL) begin
          stk[DEPTH-1] <= upc;
        end else begin
          stk[sp] <= upc;
          sp      <= sp + SPW'(1);
        end
      end else if (pop && (sp != '0)) begin
        sp <= sp - SPW'(1);
      end
    end
  end

endmodule

// File: tb/tb_microseq.sv
// Directed bench for microseq: one task per scenario, inline checks against
// hand-computed addresses, stack depths and counter values.
module tb_microseq;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    I;
  logic          cc, nCCEN, nRLD, CI;
  logic [AW-1:0] D, Y;
  logic          nPL, nMAP, nVECT, nFULL;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  microseq #(.AW(12), .DEPTH(5)) dut (
    .clk(clk), .reset(reset), .I(I), .cc(cc), .nCCEN(nCCEN), .nRLD(nRLD),
    .CI(CI), .D(D), .Y(Y), .nPL(nPL), .nMAP(nMAP), .nVECT(nVECT), .nFULL(nFULL)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] i, input logic c, input logic [AW-1:0] d);
    I  = i;
    cc = c;
    D  = d;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; I = 4'd14; cc = 1'b0; nCCEN = 1'b0; nRLD = 1'b1; CI = 1'b1; D = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    vec++; if (Y !== 12'h000) begin errs++; $display("FAIL reset_y got %h want 000", Y); end
    vec++; if (nFULL !== 1'b1) begin errs++; $display("FAIL reset_nfull got %b want 1", nFULL); end
    vec++; if (dut.sp !== 3'd0) begin errs++; $display("FAIL reset_sp got %0d want 0", dut.sp); end
    vec++; if (dut.r !== 12'h000) begin errs++; $display("FAIL reset_r got %h want 000", dut.r); end
  endtask

  task automatic test_cont;
    for (int k = 0; k < 4; k++) begin
      drive(4'd14, 1'b0, 12'h000);
      vec++; if (Y !== 12'(k)) begin errs++; $display("FAIL cont_y[%0d] got %h want %h", k, Y, 12'(k)); end
      vec++; if ({nPL, nMAP, nVECT} !== 3'b011) begin
        errs++; $display("FAIL cont_en[%0d] got %b want 011", k, {nPL, nMAP, nVECT});
      end
      tick();
    end
  endtask

  task automatic test_subroutine;
    drive(4'd3, 1'b1, 12'h00F);
    vec++; if (Y !== 12'h00F) begin errs++; $display("FAIL cjp_y got %h want 00f", Y); end
    tick();
    drive(4'd1, 1'b1, 12'h200);
    vec++; if (Y !== 12'h200) begin errs++; $display("FAIL cjs_y got %h want 200", Y); end
    tick();
    vec++; if (dut.sp !== 3'd1) begin errs++; $display("FAIL cjs_sp got %0d want 1", dut.sp); end
    drive(4'd10, 1'b1, 12'h000);
    vec++; if (Y !== 12'h010) begin errs++; $display("FAIL crtn_y got %h want 010", Y); end
    tick();
    vec++; if (dut.sp !== 3'd0) begin errs++; $display("FAIL crtn_sp got %0d want 0", dut.sp); end
    drive(4'd1, 1'b0, 12'h200);
    vec++; if (Y !== 12'h011) begin errs++; $display("FAIL cjs_fail_y got %h want 011", Y); end
    tick();
    vec++; if (dut.sp !== 3'd0) begin errs++; $display("FAIL cjs_fail_sp got %0d want 0", dut.sp); end
  endtask

  task automatic test_loop;
    logic [AW-1:0] exp_y [4];
    logic [AW-1:0] exp_r [4];
    exp_y = '{12'h013, 12'h013, 12'h013, 12'h014};
    exp_r = '{12'h002, 12'h001, 12'h000, 12'h000};
    drive(4'd12, 1'b0, 12'h003);
    vec++; if (Y !== 12'h012) begin errs++; $display("FAIL ldct_y got %h want 012", Y); end
    tick();
    drive(4'd4, 1'b0, 12'h7AA);
    vec++; if (Y !== 12'h013) begin errs++; $display("FAIL push_y got %h want 013", Y); end
    tick();
    vec++; if (dut.r !== 12'h003) begin errs++; $display("FAIL push_r got %h want 003", dut.r); end
    for (int k = 0; k < 4; k++) begin
      drive(4'd8, 1'b0, 12'h000);
      vec++; if (Y !== exp_y[k]) begin errs++; $display("FAIL rfct_y[%0d] got %h want %h", k, Y, exp_y[k]); end
      tick();
      vec++; if (dut.r !== exp_r[k]) begin errs++; $display("FAIL rfct_r[%0d] got %h want %h", k, dut.r, exp_r[k]); end
    end
    vec++; if (dut.sp !== 3'd0) begin errs++; $display("FAIL rfct_sp got %0d want 0", dut.sp); end
    drive(4'd12, 1'b0, 12'h002);
    tick();
    drive(4'd4, 1'b0, 12'h000);
    tick();
    nRLD = 1'b0;
    drive(4'd8, 1'b0, 12'h005);
    vec++; if (Y !== 12'h016) begin errs++; $display("FAIL rfct_rld_y got %h want 016", Y); end
    tick();
    nRLD = 1'b1;
    vec++; if (dut.r !== 12'h005) begin errs++; $display("FAIL rfct_rld_r got %h want 005", dut.r); end
    drive(4'd0, 1'b0, 12'h123);
    vec++; if (Y !== 12'h000) begin errs++; $display("FAIL jz_y got %h want 000", Y); end
    tick();
    vec++; if (dut.sp !== 3'd0) begin errs++; $display("FAIL jz_sp got %0d want 0", dut.sp); end
  endtask

  task automatic test_overflow;
    logic [AW-1:0] exp_y [6];
    exp_y = '{12'h006, 12'h004, 12'h003, 12'h002, 12'h001, 12'h001};
    for (int k = 0; k < 6; k++) begin
      drive(4'd4, 1'b0, 12'h000);
      tick();
      vec++; if (nFULL !== (k < 4)) begin errs++; $display("FAIL push_nfull[%0d] got %b want %b", k, nFULL, (k < 4)); end
    end
    vec++; if (dut.sp !== 3'd5) begin errs++; $display("FAIL overflow_sp got %0d want 5", dut.sp); end
    for (int k = 0; k < 6; k++) begin
      drive(4'd10, 1'b1, 12'h000);
      vec++; if (Y !== exp_y[k]) begin errs++; $display("FAIL pop_y[%0d] got %h want %h", k, Y, exp_y[k]); end
      tick();
    end
    vec++; if (dut.sp !== 3'd0) begin errs++; $display("FAIL underflow_sp got %0d want 0", dut.sp); end
    vec++; if (nFULL !== 1'b1) begin errs++; $display("FAIL underflow_nfull got %b want 1", nFULL); end
  endtask

  task automatic test_map_twb;
    drive(4'd2, 1'b0, 12'h3FF);
    vec++; if (Y !== 12'h3FF) begin errs++; $display("FAIL jmap_y got %h want 3ff", Y); end
    vec++; if ({nPL, nMAP, nVECT} !== 3'b101) begin errs++; $display("FAIL jmap_en got %b want 101", {nPL, nMAP, nVECT}); end
    tick();
    drive(4'd6, 1'b0, 12'h123);
    vec++; if (Y !== 12'h400) begin errs++; $display("FAIL cjv_y got %h want 400", Y); end
    vec++; if ({nPL, nMAP, nVECT} !== 3'b110) begin errs++; $display("FAIL cjv_en got %b want 110", {nPL, nMAP, nVECT}); end
    nCCEN = 1'b1;
    drive(4'd3, 1'b0, 12'h555);
    vec++; if (Y !== 12'h555) begin errs++; $display("FAIL forced_pass_y got %h want 555", Y); end
    nCCEN = 1'b0;
    drive(4'd6, 1'b0, 12'h123);
    tick();
    drive(4'd12, 1'b0, 12'h000);
    tick();
    drive(4'd4, 1'b0, 12'h000);
    tick();
    drive(4'd15, 1'b0, 12'h0AB);
    vec++; if (Y !== 12'h0AB) begin errs++; $display("FAIL twb_r0_y got %h want 0ab", Y); end
    tick();
    vec++; if (dut.sp !== 3'd0) begin errs++; $display("FAIL twb_r0_sp got %0d want 0", dut.sp); end
    drive(4'd12, 1'b0, 12'h001);
    tick();
    drive(4'd4, 1'b0, 12'h000);
    tick();
    drive(4'd15, 1'b0, 12'h0CD);
    vec++; if (Y !== 12'h0AD) begin errs++; $display("FAIL twb_tos_y got %h want 0ad", Y); end
    tick();
    vec++; if (dut.r !== 12'h000) begin errs++; $display("FAIL twb_tos_r got %h want 000", dut.r); end
    drive(4'd15, 1'b1, 12'h0CD);
    vec++; if (Y !== 12'h0AE) begin errs++; $display("FAIL twb_pass_y got %h want 0ae", Y); end
    tick();
    vec++; if (dut.sp !== 3'd0) begin errs++; $display("FAIL twb_pass_sp got %0d want 0", dut.sp); end
  endtask

  task automatic test_wrap_reset;
    drive(4'd3, 1'b1, 12'hFFE);
    tick();
    drive(4'd14, 1'b0, 12'h000);
    vec++; if (Y !== 12'hFFF) begin errs++; $display("FAIL wrap_pre_y got %h want fff", Y); end
    tick();
    drive(4'd14, 1'b0, 12'h000);
    vec++; if (Y !== 12'h000) begin errs++; $display("FAIL wrap_y got %h want 000", Y); end
    drive(4'd12, 1'b0, 12'h007);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(4'd4, 1'b0, 12'h000);
      tick();
    end
    vec++; if (dut.sp !== 3'd3) begin errs++; $display("FAIL pre_reset_sp got %0d want 3", dut.sp); end
    vec++; if (dut.r !== 12'h007) begin errs++; $display("FAIL pre_reset_r got %h want 007", dut.r); end
    drive(4'd10, 1'b1, 12'h000);
    vec++; if (Y !== 12'h003) begin errs++; $display("FAIL pre_reset_tos got %h want 003", Y); end
    reset = 1'b1;
    #1;
    vec++; if (dut.sp !== 3'd0) begin errs++; $display("FAIL async_sp got %0d want 0", dut.sp); end
    vec++; if (dut.r !== 12'h000) begin errs++; $display("FAIL async_r got %h want 000", dut.r); end
    vec++; if (nFULL !== 1'b1) begin errs++; $display("FAIL async_nfull got %b want 1", nFULL); end
    vec++; if (Y !== 12'h000) begin errs++; $display("FAIL async_tos got %h want 000", Y); end
    I = 4'd14;
    #1 reset = 1'b0;
    tick();
    drive(4'd14, 1'b0, 12'h000);
    vec++; if (Y !== 12'h001) begin errs++; $display("FAIL post_reset_y got %h want 001", Y); end
  endtask

  initial begin
    test_reset();
    test_cont();
    test_subroutine();
    test_loop();
    test_overflow();
    test_map_twb();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
